// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit
// Owns the fetch PC, drives word addresses into a 1-cycle synchronous-read
// instruction memory and presents {PC, IR} pairs downstream through a
// valid/ready handshake. A 2-entry buffer absorbs the fetch still in flight
// when downstream stalls. Entry 0 is always the head, and a pop shifts entry 1
// down. The downstream outputs therefore come straight from entry-0 registers.
// A redirect flushes the buffer and the in-flight fetch, then restarts at the
// target PC.

module fetch_issue_unit #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP        = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [31:0]           fd_PC,
    output logic [31:0]           fd_IR,
    output logic                  fd_valid,
    input  logic                  fd_ready,
    input  logic                  redirect,
    input  logic [31:0]           redirect_PC
);

    logic [31:0] pc_r,          pc_n_s;
    logic        inflight_r,    inflight_n_s;
    logic [31:0] inflight_pc_r, inflight_pc_n_s;
    logic        v0_r,  v0_n_s;
    logic [31:0] pc0_r, pc0_n_s;
    logic [31:0] ir0_r, ir0_n_s;
    logic        v1_r,  v1_n_s;
    logic [31:0] pc1_r, pc1_n_s;
    logic [31:0] ir1_r, ir1_n_s;
    logic        pop_s;
    logic        issue_s;

    // Memory sees the low PC bits. Higher PCs alias, but fd_PC keeps all 32 bits.
    assign imem_addr = pc_r[ADDR_WIDTH-1:0];
    assign fd_PC     = pc0_r;
    assign fd_IR     = ir0_r;
    assign fd_valid  = v0_r;

    // Next-state logic: redirect first, then pop, issue decision, capture.
    always_comb begin
        pc_n_s          = pc_r;
        inflight_n_s    = 1'b0;
        inflight_pc_n_s = inflight_pc_r;
        v0_n_s          = v0_r;
        pc0_n_s         = pc0_r;
        ir0_n_s         = ir0_r;
        v1_n_s          = v1_r;
        pc1_n_s         = pc1_r;
        ir1_n_s         = ir1_r;
        pop_s           = v0_r & fd_ready;
        issue_s         = 1'b0;

        if (redirect) begin
            // A head handed over at this edge is downstream's to squash.
            pc_n_s       = redirect_PC;
            inflight_n_s = 1'b0;
            v0_n_s       = 1'b0;
            v1_n_s       = 1'b0;
            ir0_n_s      = NOP;
        end else begin
            if (pop_s) begin
                if (v1_r) begin
                    pc0_n_s = pc1_r;
                    ir0_n_s = ir1_r;
                end else begin
                    ir0_n_s = NOP;
                end
                v0_n_s = v1_r;
                v1_n_s = 1'b0;
            end else begin
                v0_n_s = v0_r;
            end

            // Issue only if the post-pop occupancy plus the pending return
            // leaves room for one more result.
            issue_s = ~(v0_n_s & (v1_n_s | inflight_r));

            if (inflight_r) begin
                if (!v0_n_s) begin
                    v0_n_s  = 1'b1;
                    pc0_n_s = inflight_pc_r;
                    ir0_n_s = imem_data;
                end else begin
                    v1_n_s  = 1'b1;
                    pc1_n_s = inflight_pc_r;
                    ir1_n_s = imem_data;
                end
            end else begin
                inflight_n_s = 1'b0;
            end

            if (issue_s) begin
                pc_n_s          = pc_r + 32'd1;
                inflight_n_s    = 1'b1;
                inflight_pc_n_s = pc_r;
            end else begin
                inflight_n_s    = 1'b0;
            end

            if (!v0_n_s) begin
                ir0_n_s = NOP;
            end else begin
                ir0_n_s = ir0_n_s;
            end
        end
    end

    // State registers: asynchronous clear to reset values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 32'h0000_0000;
            v0_r          <= 1'b0;
            pc0_r         <= 32'h0000_0000;
            ir0_r         <= NOP;
            v1_r          <= 1'b0;
            pc1_r         <= 32'h0000_0000;
            ir1_r         <= NOP;
        end else begin
            pc_r          <= pc_n_s;
            inflight_r    <= inflight_n_s;
            inflight_pc_r <= inflight_pc_n_s;
            v0_r          <= v0_n_s;
            pc0_r         <= pc0_n_s;
            ir0_r         <= ir0_n_s;
            v1_r          <= v1_n_s;
            pc1_r         <= pc1_n_s;
            ir1_r         <= ir1_n_s;
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit. The main instance uses RESET_PC=0 and
// is driven through streaming, stall, redirect, redirect-while-stalled and
// mid-stall reset. A second instance with RESET_PC=FFF checks address
// truncation. Both memory models return 100+address, one cycle after the
// address is sampled.

module tb_fetch_issue_unit;

    logic        clk;
    logic        reset;
    logic        fd_ready;
    logic        redirect;
    logic [31:0] redirect_PC;

    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] fd_PC;
    logic [31:0] fd_IR;
    logic        fd_valid;

    logic [11:0] w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_fd_PC;
    logic [31:0] w_fd_IR;
    logic        w_fd_valid;

    int n_vec;
    int n_bad;

    fetch_issue_unit #(.ADDR_WIDTH(12), .RESET_PC(32'h0000_0000), .NOP(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .fd_PC(fd_PC), .fd_IR(fd_IR), .fd_valid(fd_valid), .fd_ready(fd_ready),
        .redirect(redirect), .redirect_PC(redirect_PC)
    );

    fetch_issue_unit #(.ADDR_WIDTH(12), .RESET_PC(32'h0000_0FFF), .NOP(32'h0000_0000)) u_wrap (
        .clk(clk), .reset(reset), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .fd_PC(w_fd_PC), .fd_IR(w_fd_IR), .fd_valid(w_fd_valid), .fd_ready(1'b1),
        .redirect(1'b0), .redirect_PC(32'h0000_0000)
    );

    // Clock: period 10, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read instruction memories: word at address a is 100+a.
    always @(posedge clk) begin
        imem_data   <= 32'd100 + {20'd0, imem_addr};
        w_imem_data <= 32'd100 + {20'd0, w_imem_addr};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the full output pair of the main instance.
    task automatic chk_pair(input string tag, input logic [31:0] pc, input logic [31:0] ir);
        chk({tag, ".valid"}, {31'd0, fd_valid}, 32'd1);
        chk({tag, ".pc"}, fd_PC, pc);
        chk({tag, ".ir"}, fd_IR, ir);
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        fd_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_PC = 32'h0000_0000;

        // Reset values.
        tick();
        tick();
        chk("rst.valid", {31'd0, fd_valid}, 32'd0);
        chk("rst.pc", fd_PC, 32'd0);
        chk("rst.ir", fd_IR, 32'd0);
        chk("rst.addr", {20'd0, imem_addr}, 32'd0);
        chk("rst.waddr", {20'd0, w_imem_addr}, 32'h0000_0FFF);
        reset = 1'b1;

        // Test 1 and test 5: streaming from reset.
        tick();  // E0
        chk("e0.valid", {31'd0, fd_valid}, 32'd0);
        chk("e0.addr", {20'd0, imem_addr}, 32'd1);
        chk("e0.waddr", {20'd0, w_imem_addr}, 32'd0);
        tick();  // E1
        chk_pair("e1", 32'd0, 32'd100);
        chk("wrap.pc0", w_fd_PC, 32'h0000_0FFF);
        chk("wrap.ir0", w_fd_IR, 32'd4195);
        chk("wrap.v0", {31'd0, w_fd_valid}, 32'd1);
        tick();  // E2
        chk_pair("e2", 32'd1, 32'd101);
        chk("wrap.pc1", w_fd_PC, 32'h0000_1000);
        chk("wrap.ir1", w_fd_IR, 32'd100);
        tick();  // E3
        chk_pair("e3", 32'd2, 32'd102);
        tick();  // E4
        chk_pair("e4", 32'd3, 32'd103);

        // Test 2: stall five cycles at PC 3.
        fd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_pair("stall", 32'd3, 32'd103);
            chk("stall.addr", {20'd0, imem_addr}, 32'd5);
        end
        fd_ready = 1'b1;
        for (int k = 4; k < 8; k++) begin
            tick();
            chk_pair("resume", k, 32'd100 + k);
        end

        // Test 3: redirect while streaming.
        redirect    = 1'b1;
        redirect_PC = 32'd40;
        tick();
        redirect = 1'b0;
        chk("rd.valid", {31'd0, fd_valid}, 32'd0);
        chk("rd.ir", fd_IR, 32'd0);
        tick();
        chk("rd1.valid", {31'd0, fd_valid}, 32'd0);
        tick();
        chk_pair("rd2", 32'd40, 32'd140);
        tick();
        chk_pair("rd3", 32'd41, 32'd141);

        // Test 4: redirect during a full stall.
        fd_ready = 1'b0;
        tick();
        tick();
        chk_pair("full", 32'd41, 32'd141);
        redirect    = 1'b1;
        redirect_PC = 32'd200;
        tick();
        redirect = 1'b0;
        chk("fl.valid", {31'd0, fd_valid}, 32'd0);
        chk("fl.ir", fd_IR, 32'd0);
        tick();
        chk("fl1.valid", {31'd0, fd_valid}, 32'd0);
        tick();
        chk_pair("fl2", 32'd200, 32'd300);
        tick();
        chk_pair("fl3", 32'd200, 32'd300);
        fd_ready = 1'b1;
        tick();
        chk_pair("fl4", 32'd201, 32'd301);

        // Test 6: asynchronous reset in the middle of a stall.
        fd_ready = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("ar.valid", {31'd0, fd_valid}, 32'd0);
        chk("ar.pc", fd_PC, 32'd0);
        chk("ar.ir", fd_IR, 32'd0);
        chk("ar.addr", {20'd0, imem_addr}, 32'd0);
        tick();
        reset    = 1'b1;
        fd_ready = 1'b1;
        tick();
        chk("ar0.valid", {31'd0, fd_valid}, 32'd0);
        tick();
        chk_pair("ar1", 32'd0, 32'd100);
        tick();
        chk_pair("ar2", 32'd1, 32'd101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
